s15611_pixel_capture: RTL and testbench

- Receive side of the S15611 (CJMCU-1401) line-sensor readout.
- Frames on the SI pulse and the per-pixel sample_capture_trigger from the sensor driver.
- For each pixel, runs a convert/busy handshake with an external ADC, captures the sample and buffers it in a small FIFO.
- Emits one AXI4-Stream line of NUMBER_OF_PIXEL words per SI period to the PS/DMA side.

---
 rtl/s15611_pkg.sv | 24 ++
 rtl/s15611_sample_fifo.sv | 45 ++++
 rtl/s15611_pixel_capture.sv | 186 ++++++++++++++++++
 tb/tb_s15611_pixel_capture.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/s15611_pkg.sv
// Shared types for the S15611 line-sensor capture path: FSM states and the
// word format carried through the output FIFO.
package s15611_pkg;

  localparam int DEFAULT_NUMBER_OF_PIXEL = 128;
  localparam int TDATA_WIDTH             = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CONVST,
    WAIT_BUSY_HI,
    WAIT_BUSY_LO,
    STORE,
    DONE
  } capture_state_t;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic                   first;
    logic                   last;
  } pixel_word_t;

endpackage

// File: rtl/s15611_sample_fifo.sv
// First-word-fall-through FIFO between the capture FSM and the AXI4-Stream port.
// A write into a full FIFO is refused, so push never races a pop when full.
module s15611_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 18
) (
  input  logic             master_clock,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge master_clock) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/s15611_pixel_capture.sv
// Receive side of the S15611 readout: frames lines on SI, runs the ADC
// convert/busy handshake per pixel trigger and streams one line per SI period.
module s15611_pixel_capture
  import s15611_pkg::*;
#(
  parameter int NUMBER_OF_PIXEL   = DEFAULT_NUMBER_OF_PIXEL,
  parameter int ADC_WIDTH         = 12,
  parameter int CONVST_NCLK       = 2,
  parameter int BUSY_TIMEOUT_NCLK = 64,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic                 master_clock,
  input  logic                 resetn,
  input  logic                 sensor_si,
  input  logic                 sample_capture_trigger,
  output logic                 adc_convst,
  input  logic                 adc_busy,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic [15:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 clear_errors,
  output logic                 err_missed,
  output logic                 err_timeout,
  output logic                 err_overflow,
  output logic                 err_short_frame,
  output logic [15:0]          frame_count
);

  localparam int                 PIX_W        = $clog2(NUMBER_OF_PIXEL) + 1;
  localparam logic [PIX_W-1:0]   LAST_INDEX   = PIX_W'(NUMBER_OF_PIXEL - 1);
  localparam logic [PIX_W-1:0]   PIX_COUNT    = PIX_W'(NUMBER_OF_PIXEL);
  localparam int                 CNT_W        = $clog2(BUSY_TIMEOUT_NCLK + CONVST_NCLK + 1);
  localparam logic [CNT_W-1:0]   CONVST_LAST  = CNT_W'(CONVST_NCLK - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT_NCLK - 1);

  capture_state_t   state;
  logic [PIX_W-1:0] pixel_index;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      sample;
  logic             si_q;
  logic             si_pending;
  logic             busy_meta;
  logic             busy_sync;
  logic             si_rise;
  logic             si_applicable;
  logic             converting;
  logic             fifo_full;
  logic             fifo_empty;
  pixel_word_t      wr_word;
  pixel_word_t      rd_word;

  assign si_rise       = sensor_si && !si_q;
  assign si_applicable = (state == IDLE) || (state == ARMED) || (state == DONE);
  assign converting    = (state == CONVST) || (state == WAIT_BUSY_HI) ||
                         (state == WAIT_BUSY_LO) || (state == STORE);

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      si_q      <= 1'b0;
      busy_meta <= 1'b0;
      busy_sync <= 1'b0;
    end else begin
      si_q      <= sensor_si;
      busy_meta <= adc_busy;
      busy_sync <= busy_meta;
    end
  end

  // Clears are written first so a same-cycle set further down wins.
  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      pixel_index     <= '0;
      cnt             <= '0;
      sample          <= '0;
      si_pending      <= 1'b0;
      adc_convst      <= 1'b0;
      err_missed      <= 1'b0;
      err_timeout     <= 1'b0;
      err_overflow    <= 1'b0;
      err_short_frame <= 1'b0;
      frame_count     <= '0;
    end else begin
      if (clear_errors) begin
        err_missed      <= 1'b0;
        err_timeout     <= 1'b0;
        err_overflow    <= 1'b0;
        err_short_frame <= 1'b0;
      end
      if (si_rise && !si_applicable)
        si_pending <= 1'b1;
      if (si_applicable && (si_rise || si_pending)) begin
        si_pending  <= 1'b0;
        state       <= ARMED;
        pixel_index <= '0;
        if ((pixel_index != '0) && (pixel_index < PIX_COUNT))
          err_short_frame <= 1'b1;
      end else begin
        unique case (state)
          ARMED: begin
            if (sample_capture_trigger) begin
              state      <= CONVST;
              adc_convst <= 1'b1;
              cnt        <= '0;
            end
          end
          CONVST: begin
            if (cnt == CONVST_LAST) begin
              adc_convst <= 1'b0;
              cnt        <= '0;
              state      <= WAIT_BUSY_HI;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_BUSY_HI: begin
            if (busy_sync) begin
              cnt   <= '0;
              state <= WAIT_BUSY_LO;
            end else if (cnt == TIMEOUT_LAST) begin
              err_timeout <= 1'b1;
              sample      <= '0;
              state       <= STORE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_BUSY_LO: begin
            if (!busy_sync) begin
              sample <= 16'(adc_data);
              state  <= STORE;
            end else if (cnt == TIMEOUT_LAST) begin
              err_timeout <= 1'b1;
              sample      <= '0;
              state       <= STORE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STORE: begin
            if (fifo_full)
              err_overflow <= 1'b1;
            pixel_index <= pixel_index + 1'b1;
            if (pixel_index == LAST_INDEX) begin
              state       <= DONE;
              frame_count <= frame_count + 16'd1;
            end else begin
              state <= ARMED;
            end
          end
          default: ;
        endcase
      end
      if (sample_capture_trigger && converting)
        err_missed <= 1'b1;
    end
  end

  assign wr_word.data  = sample;
  assign wr_word.first = (pixel_index == '0);
  assign wr_word.last  = (pixel_index == LAST_INDEX);

  s15611_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_word_t))
  ) u_fifo (
    .master_clock (master_clock),
    .resetn       (resetn),
    .wr_en        (state == STORE),
    .wr_data      (wr_word),
    .rd_en        (m_axis_tready),
    .rd_data      (rd_word),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  // Unwritten FIFO entries are never exposed, so the stream reads 0 when empty.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? 16'd0 : rd_word.data;
  assign m_axis_tuser  = !fifo_empty && rd_word.first;
  assign m_axis_tlast  = !fifo_empty && rd_word.last;

endmodule

// File: tb/tb_s15611_pixel_capture.sv
// Scoreboard bench for s15611_pixel_capture with a behavioural ADC model.
module tb_s15611_pixel_capture;
  import s15611_pkg::*;

  localparam int NUM   = 128;
  localparam int ADC_W = 12;
  localparam int DEPTH = 16;

  logic              master_clock           = 1'b0;
  logic              resetn                 = 1'b1;
  logic              sensor_si              = 1'b0;
  logic              sample_capture_trigger = 1'b0;
  logic              adc_busy               = 1'b0;
  logic [ADC_W-1:0]  adc_data               = '0;
  logic              m_axis_tready          = 1'b1;
  logic              clear_errors           = 1'b0;
  logic              adc_convst;
  logic [15:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic              err_missed;
  logic              err_timeout;
  logic              err_overflow;
  logic              err_short_frame;
  logic [15:0]       frame_count;

  pixel_word_t       sb[$];
  pixel_word_t       exp_word;
  int                vectors      = 0;
  int                miscompares  = 0;
  int                exp_frames   = 0;
  int                convst_count = 0;
  logic [ADC_W-1:0]  adc_value    = '0;
  bit                adc_stuck    = 1'b0;

  s15611_pixel_capture #(
    .NUMBER_OF_PIXEL   (NUM),
    .ADC_WIDTH         (ADC_W),
    .CONVST_NCLK       (2),
    .BUSY_TIMEOUT_NCLK (64),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .master_clock           (master_clock),
    .resetn                 (resetn),
    .sensor_si              (sensor_si),
    .sample_capture_trigger (sample_capture_trigger),
    .adc_convst             (adc_convst),
    .adc_busy               (adc_busy),
    .adc_data               (adc_data),
    .m_axis_tdata           (m_axis_tdata),
    .m_axis_tvalid          (m_axis_tvalid),
    .m_axis_tready          (m_axis_tready),
    .m_axis_tlast           (m_axis_tlast),
    .m_axis_tuser           (m_axis_tuser),
    .clear_errors           (clear_errors),
    .err_missed             (err_missed),
    .err_timeout            (err_timeout),
    .err_overflow           (err_overflow),
    .err_short_frame        (err_short_frame),
    .frame_count            (frame_count)
  );

  always #5 master_clock = ~master_clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // ADC model: garbage on the bus while busy, the real result once busy falls.
  initial begin
    forever begin
      @(posedge adc_convst);
      convst_count++;
      if (!adc_stuck) begin
        repeat (2) @(posedge master_clock);
        #1;
        adc_busy = 1'b1;
        adc_data = 12'hABC;
        repeat (10) @(posedge master_clock);
        #1;
        adc_data = adc_value;
        adc_busy = 1'b0;
      end
    end
  end

  always @(negedge master_clock) begin
    if (resetn && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        checkOutput("extra_beat", 32'(m_axis_tvalid), 32'd0);
      end else begin
        exp_word = sb.pop_front();
        checkOutput("beat", {14'd0, m_axis_tdata, m_axis_tuser, m_axis_tlast}, {14'd0, exp_word});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge master_clock);
    #1;
  endtask

  task automatic pulseTrigger();
    sample_capture_trigger = 1'b1;
    tick(1);
    sample_capture_trigger = 1'b0;
  endtask

  task automatic pulseSi();
    sensor_si = 1'b1;
    tick(2);
    sensor_si = 1'b0;
    tick(4);
  endtask

  task automatic clearFlags();
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
    tick(1);
  endtask

  task automatic checkFlags(input string tag, input bit m, input bit t, input bit o, input bit s);
    checkOutput({tag, "_err_missed"},      32'(err_missed),      32'(m));
    checkOutput({tag, "_err_timeout"},     32'(err_timeout),     32'(t));
    checkOutput({tag, "_err_overflow"},    32'(err_overflow),    32'(o));
    checkOutput({tag, "_err_short_frame"}, 32'(err_short_frame), 32'(s));
  endtask

  task automatic waitDrain(input string tag);
    for (int k = 0; k < 600 && sb.size() != 0; k++)
      tick(1);
    tick(3);
    checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  // One SI followed by n_pix pixel triggers; expected words are queued as driven.
  task automatic applyStimulus(input int n_pix, input int spacing, input int seed,
                               input int stuck_pix, input int double_pix, input bit dbl_clear,
                               input int bp_start, input int bp_end, input int keep_limit);
    pulseSi();
    for (int i = 0; i < n_pix; i++) begin
      pixel_word_t w;
      if (i == bp_start) m_axis_tready = 1'b0;
      if (i == bp_end)   m_axis_tready = 1'b1;
      adc_stuck = (i == stuck_pix);
      adc_value = ADC_W'(seed + i);
      w.data    = (i == stuck_pix) ? 16'd0 : 16'(adc_value);
      w.first   = (i == 0);
      w.last    = (i == NUM - 1);
      if (i < keep_limit) sb.push_back(w);
      pulseTrigger();
      if (i == double_pix) begin
        tick(4);
        sample_capture_trigger = 1'b1;
        clear_errors           = dbl_clear;
        tick(1);
        sample_capture_trigger = 1'b0;
        clear_errors           = 1'b0;
      end
      tick(spacing);
    end
    adc_stuck = 1'b0;
    if (n_pix == NUM) exp_frames++;
  endtask

  initial begin
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst_convst",      32'(adc_convst),    32'd0);
    checkOutput("rst_tvalid",      32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_tdata",       32'(m_axis_tdata),  32'd0);
    checkOutput("rst_tlast_tuser", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count),   32'd0);
    checkFlags("rst", 0, 0, 0, 0);
    tick(2);
    resetn = 1'b1;
    tick(2);

    $display("[TB] triggers before first SI");
    for (int i = 0; i < 3; i++) begin
      pulseTrigger();
      tick(10);
    end
    tick(20);
    checkOutput("idle_convst_count", 32'(convst_count), 32'd0);
    checkOutput("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkFlags("idle", 0, 0, 0, 0);

    $display("[TB] nominal line");
    applyStimulus(NUM, 200, 0, -1, -1, 1'b0, -1, -1, NUM);
    waitDrain("nominal");
    checkOutput("nominal_frame_count", 32'(frame_count), 32'(exp_frames));
    checkFlags("nominal", 0, 0, 0, 0);

    $display("[TB] backpressure on beats 5..20");
    applyStimulus(NUM, 30, 12'h100, -1, -1, 1'b0, 5, 21, NUM);
    waitDrain("bp");
    checkOutput("bp_frame_count", 32'(frame_count), 32'(exp_frames));
    checkFlags("bp", 0, 0, 0, 0);

    $display("[TB] backpressure for whole line");
    applyStimulus(NUM, 30, 12'h200, -1, -1, 1'b0, 0, -1, DEPTH);
    checkOutput("ovf_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    checkFlags("ovf", 0, 0, 1, 0);
    m_axis_tready = 1'b1;
    waitDrain("ovf");
    checkOutput("ovf_frame_count", 32'(frame_count), 32'(exp_frames));
    clearFlags();
    checkFlags("ovf_cleared", 0, 0, 0, 0);

    $display("[TB] busy stuck low on pixel 3");
    applyStimulus(NUM, 80, 12'hF00, 3, -1, 1'b0, -1, -1, NUM);
    waitDrain("timeout");
    checkOutput("timeout_frame_count", 32'(frame_count), 32'(exp_frames));
    checkFlags("timeout", 0, 1, 0, 0);
    clearFlags();

    $display("[TB] trigger during conversion");
    applyStimulus(NUM, 30, 12'h300, -1, 7, 1'b0, -1, -1, NUM);
    waitDrain("missed");
    checkFlags("missed", 1, 0, 0, 0);
    clearFlags();
    checkOutput("missed_cleared", 32'(err_missed), 32'd0);
    applyStimulus(NUM, 30, 12'h400, -1, 2, 1'b1, -1, -1, NUM);
    waitDrain("missed_clr");
    checkOutput("missed_set_and_clear", 32'(err_missed), 32'd1);
    checkOutput("missed_frame_count", 32'(frame_count), 32'(exp_frames));
    clearFlags();

    $display("[TB] short frame");
    applyStimulus(60, 30, 12'h500, -1, -1, 1'b0, -1, -1, NUM);
    applyStimulus(NUM, 30, 12'h600, -1, -1, 1'b0, -1, -1, NUM);
    waitDrain("short");
    checkFlags("short", 0, 0, 0, 1);
    checkOutput("short_frame_count", 32'(frame_count), 32'(exp_frames));
    clearFlags();

    $display("[TB] reset mid-conversion");
    applyStimulus(3, 30, 12'h700, -1, -1, 1'b0, 0, -1, NUM);
    pulseTrigger();
    tick(8);
    resetn = 1'b0;
    #1;
    checkOutput("midrst_convst",      32'(adc_convst),    32'd0);
    checkOutput("midrst_tvalid",      32'(m_axis_tvalid), 32'd0);
    checkOutput("midrst_frame_count", 32'(frame_count),   32'd0);
    sb.delete();
    exp_frames = 0;
    tick(3);
    resetn        = 1'b1;
    m_axis_tready = 1'b1;
    tick(20);
    applyStimulus(NUM, 30, 12'h800, -1, -1, 1'b0, -1, -1, NUM);
    waitDrain("post_rst");
    checkOutput("post_rst_frame_count", 32'(frame_count), 32'(exp_frames));
    checkFlags("post_rst", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
